// File: rtl/slib_rx_bit_sequencer.sv
// UART receive bit sequencer: start detect, per-bit tick timing and
// framing around an external majority-vote filter.
module slib_rx_bit_sequencer #(
   parameter int OVERSAMPLE = 16,
   parameter int WIN_START  = 6,
   parameter int WIN_LEN    = 5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BAUDCE,
   input  logic       RXD,
   input  logic [1:0] WLS,
   input  logic       PEN,
   input  logic       EPS,
   output logic       FLT_SAMPLE,
   output logic       FLT_CLEAR,
   input  logic       FLT_Q,
   output logic [7:0] DOUT,
   output logic       DVALID,
   output logic       PE,
   output logic       FE,
   output logic       BUSY
);

   localparam int TC_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
   localparam logic [TC_W-1:0] TC_WLO  = TC_W'(WIN_START);
   localparam logic [TC_W-1:0] TC_WHI  = TC_W'(WIN_START + WIN_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t          state;
   logic [TC_W-1:0] tc;
   logic [2:0]      idx;
   logic [1:0]      wls_q;
   logic            pen_q;
   logic            eps_q;
   logic [7:0]      shreg;
   logic            par_err;

   logic bit_end;
   logic start_det;
   logic in_win;
   logic last_data;
   logic exp_par;

   assign bit_end   = BAUDCE && (tc == TC_LAST);
   assign start_det = (state == IDLE) && BAUDCE && !RXD;
   assign in_win    = (tc >= TC_WLO) && (tc <= TC_WHI);
   assign last_data = (idx == ({1'b0, wls_q} + 3'd4));
   // even parity select: expected bit is the data XOR, else its inverse
   assign exp_par   = (^shreg) ^ ~eps_q;

   assign FLT_CLEAR  = RST || start_det ||
                       ((state != IDLE) && bit_end);
   assign FLT_SAMPLE = !RST && BAUDCE &&
                       (state != IDLE) && in_win;
   assign BUSY       = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         tc      <= '0;
         idx     <= '0;
         wls_q   <= '0;
         pen_q   <= 1'b0;
         eps_q   <= 1'b0;
         shreg   <= '0;
         par_err <= 1'b0;
         DOUT    <= '0;
         DVALID  <= 1'b0;
         PE      <= 1'b0;
         FE      <= 1'b0;
      end else begin
         DVALID <= 1'b0;
         if (BAUDCE) begin
            unique case (state)
               IDLE: begin
                  if (!RXD) begin
                     state   <= START;
                     tc      <= '0;
                     idx     <= '0;
                     wls_q   <= WLS;
                     pen_q   <= PEN;
                     eps_q   <= EPS;
                     shreg   <= '0;
                     par_err <= 1'b0;
                  end
               end
               default: begin
                  tc <= bit_end ? '0 : tc + 1'b1;
                  if (bit_end) begin
                     unique case (state)
                        START: begin
                           if (FLT_Q) begin
                              state <= IDLE;
                           end else begin
                              state <= DATA;
                              idx   <= '0;
                           end
                        end
                        DATA: begin
                           shreg[idx] <= FLT_Q;
                           if (last_data) begin
                              state <= pen_q ? PARITY : STOP;
                           end else begin
                              idx <= idx + 3'd1;
                           end
                        end
                        PARITY: begin
                           par_err <= (FLT_Q != exp_par);
                           state   <= STOP;
                        end
                        default: begin
                           DVALID <= 1'b1;
                           DOUT   <= shreg;
                           PE     <= pen_q && par_err;
                           FE     <= !FLT_Q;
                           state  <= IDLE;
                        end
                     endcase
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slib_rx_bit_sequencer.sv
// Bench for slib_rx_bit_sequencer: frame-level reference model,
// majority-vote filter stand-in and per-cycle output checks.
module tb_slib_rx_bit_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BAUDCE = 1'b0;
   logic       RXD = 1'b1;
   logic [1:0] WLS = 2'd0;
   logic       PEN = 1'b0;
   logic       EPS = 1'b0;
   logic       FLT_SAMPLE;
   logic       FLT_CLEAR;
   logic       FLT_Q;
   logic [7:0] DOUT;
   logic       DVALID;
   logic       PE;
   logic       FE;
   logic       BUSY;

   int vectors = 0;
   int miscompares = 0;

   slib_rx_bit_sequencer dut (
      .CLK(CLK),
      .RST(RST),
      .BAUDCE(BAUDCE),
      .RXD(RXD),
      .WLS(WLS),
      .PEN(PEN),
      .EPS(EPS),
      .FLT_SAMPLE(FLT_SAMPLE),
      .FLT_CLEAR(FLT_CLEAR),
      .FLT_Q(FLT_Q),
      .DOUT(DOUT),
      .DVALID(DVALID),
      .PE(PE),
      .FE(FE),
      .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // majority-of-five filter with D tied to RXD
   logic [3:0] ones = 4'd0;
   assign FLT_Q = (ones >= 4'd3);
   always @(posedge CLK) begin
      if (FLT_CLEAR) ones <= 4'd0;
      else if (FLT_SAMPLE && RXD) ones <= ones + 4'd1;
   end

   typedef struct {
      logic [7:0] dout;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t       expq[$];
   exp_t       cur_e;
   logic [7:0] h_dout = 8'd0;
   logic       h_pe = 1'b0;
   logic       h_fe = 1'b0;
   int         dv_count = 0;
   int         scnt = 0;
   bit         chk_en = 1'b0;
   logic [1:0] cur_wls = 2'd0;
   logic       cur_pen = 1'b0;
   logic       cur_eps = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         if (FLT_SAMPLE || FLT_CLEAR)
            chk("sample_clear_overlap", 32'(FLT_SAMPLE & FLT_CLEAR), 0);
         if (RST) begin
            scnt = 0;
         end else if (FLT_CLEAR) begin
            if (BUSY) chk("samples_per_bit", scnt, 5);
            scnt = 0;
         end else if (FLT_SAMPLE) begin
            scnt++;
         end
         if (DVALID) begin
            dv_count++;
            if (expq.size() == 0) begin
               chk("unexpected_dvalid", 32'(DVALID), 0);
            end else begin
               cur_e = expq.pop_front();
               chk("dout", 32'(DOUT), 32'(cur_e.dout));
               chk("pe", 32'(PE), 32'(cur_e.pe));
               chk("fe", 32'(FE), 32'(cur_e.fe));
               chk("busy_at_dvalid", 32'(BUSY), 0);
               h_dout = cur_e.dout;
               h_pe = cur_e.pe;
               h_fe = cur_e.fe;
            end
         end else begin
            chk("hold_dout", 32'(DOUT), 32'(h_dout));
            chk("hold_pe", 32'(PE), 32'(h_pe));
            chk("hold_fe", 32'(FE), 32'(h_fe));
         end
         if (RST) begin
            h_dout = 8'd0;
            h_pe = 1'b0;
            h_fe = 1'b0;
         end
      end
   end

   // one oversample tick followed by three quiet cycles of line noise
   task automatic do_tick(input logic v, input bit hold);
      RXD = v;
      BAUDCE = 1'b1;
      if (hold) begin
         WLS = cur_wls;
         PEN = cur_pen;
         EPS = cur_eps;
      end else begin
         WLS = 2'($urandom);
         PEN = 1'($urandom);
         EPS = 1'($urandom);
      end
      @(posedge CLK); #1;
      BAUDCE = 1'b0;
      repeat (3) begin
         RXD = 1'($urandom);
         WLS = 2'($urandom);
         PEN = 1'($urandom);
         EPS = 1'($urandom);
         @(posedge CLK); #1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_tick(1'b1, 1'b0);
   endtask

   task automatic reset_mid();
      RST = 1'b1;
      BAUDCE = 1'b1;
      RXD = 1'b0;
      #1;
      chk("rst_flt_clear", 32'(FLT_CLEAR), 1);
      chk("rst_flt_sample", 32'(FLT_SAMPLE), 0);
      @(posedge CLK); #1;
      chk("rst_dout", 32'(DOUT), 0);
      chk("rst_dvalid", 32'(DVALID), 0);
      chk("rst_pe", 32'(PE), 0);
      chk("rst_fe", 32'(FE), 0);
      chk("rst_busy", 32'(BUSY), 0);
      RST = 1'b0;
      BAUDCE = 1'b0;
      RXD = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] wls,
                             input logic pen, input logic eps,
                             input logic par, input logic stp,
                             input int abort_at, input bit glitch);
      logic bits[$];
      int   n;
      int   g;
      int   odd;
      bit   aborted;
      exp_t e;
      n = int'(wls) + 5;
      cur_wls = wls;
      cur_pen = pen;
      cur_eps = eps;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(par);
      bits.push_back(stp);
      e.dout = 8'((16'd1 << n) - 16'd1) & d;
      odd = $countones(e.dout) % 2;
      e.pe = pen && (int'(par) != (eps ? odd : 1 - odd));
      e.fe = !stp;
      aborted = 1'b0;
      for (int b = 0; b < bits.size(); b++) begin
         g = glitch ? int'($urandom_range(1, 15)) : -1;
         if (b == bits.size() - 1) expq.push_back(e);
         for (int t = 0; t < 16; t++) begin
            if (abort_at >= 0 && b == abort_at + 1 && t == 8) begin
               reset_mid();
               aborted = 1'b1;
               break;
            end
            do_tick((t == g) ? ~bits[b] : bits[b], b == 0 && t == 0);
         end
         if (aborted) break;
      end
   endtask

   int d0;

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      chk("init_flt_clear", 32'(FLT_CLEAR), 1);
      chk("init_flt_sample", 32'(FLT_SAMPLE), 0);
      chk("init_dout", 32'(DOUT), 0);
      chk("init_dvalid", 32'(DVALID), 0);
      chk("init_pe", 32'(PE), 0);
      chk("init_fe", 32'(FE), 0);
      chk("init_busy", 32'(BUSY), 0);
      RST = 1'b0;
      chk_en = 1'b1;
      idle(5);

      d0 = dv_count;
      send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      chk("a5_dvalid_count", dv_count - d0, 1);
      chk("a5_dout", 32'(DOUT), 32'hA5);
      chk("a5_pe", 32'(PE), 0);
      chk("a5_fe", 32'(FE), 0);
      chk("a5_busy", 32'(BUSY), 0);

      send_frame(8'hF6, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      chk("p5_dout", 32'(DOUT), 32'h16);
      chk("p5_pe_bad", 32'(PE), 1);
      send_frame(8'hF6, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
      idle(4);
      chk("p5_pe_good", 32'(PE), 0);

      d0 = dv_count;
      cur_wls = 2'd3;
      cur_pen = 1'b0;
      cur_eps = 1'b0;
      do_tick(1'b0, 1'b1);
      do_tick(1'b0, 1'b0);
      do_tick(1'b0, 1'b0);
      chk("glitch_busy_mid", 32'(BUSY), 1);
      idle(20);
      chk("glitch_busy_after", 32'(BUSY), 0);
      chk("glitch_no_dvalid", dv_count - d0, 0);

      send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      idle(4);
      chk("fe_dout", 32'(DOUT), 32'h3C);
      chk("fe_fe", 32'(FE), 1);

      send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
      idle(6);
      send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      chk("after_rst_dout", 32'(DOUT), 32'h5A);
      chk("after_rst_fe", 32'(FE), 0);

      for (int k = 0; k < 30; k++) begin
         send_frame(8'($urandom), 2'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom),
                    $urandom_range(0, 4) != 0, -1,
                    1'($urandom));
         idle(int'($urandom_range(1, 6)));
      end
      idle(4);
      chk("frames_outstanding", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/slib_rx_bit_sequencer.md
SLIB_RX_BIT_SEQUENCER -- requirements
Module: slib_rx_bit_sequencer

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning BAUDCE ticks per serial bit.
REQ-002 SHALL have parameter WIN_START, default 6, meaning first tick index of the vote window; legal range 1 to OVERSAMPLE-2.
REQ-003 SHALL have parameter WIN_LEN, default 5, meaning vote window length in ticks; WIN_START+WIN_LEN SHALL be at most OVERSAMPLE-1.
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port BAUDCE, input, 1, oversample tick, one CLK wide.
REQ-007 SHALL have port RXD, input, 1, serial line, already synchronised, idle high.
REQ-008 SHALL have port WLS, input, 2, word length select: 0..3 gives 5..8 data bits.
REQ-009 SHALL have ports PEN and EPS, inputs, 1 each: parity enable; even parity select.
REQ-010 SHALL have ports FLT_SAMPLE and FLT_CLEAR, outputs, 1 each, driving the majority-vote filter SAMPLE and CLEAR; the filter D is tied to RXD.
REQ-011 SHALL have port FLT_Q, input, 1, the filter's voted bit value.
REQ-012 SHALL have ports DOUT (output, 8), DVALID (output, 1), PE (output, 1), FE (output, 1) and BUSY (output, 1).

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY and STOP, plus a tick counter TC running 0..OVERSAMPLE-1 that advances only on BAUDCE.
REQ-014 In IDLE, BAUDCE=1 with RXD=0 SHALL cause: enter START, TC=0, FLT_CLEAR=1 that cycle, and latch WLS/PEN/EPS.
REQ-015 Config SHALL be frozen from start detect to frame end; mid-frame WLS/PEN/EPS changes SHALL have no effect.
REQ-016 Outside IDLE, FLT_CLEAR SHALL be 1 exactly in the BAUDCE cycle in which TC wraps from OVERSAMPLE-1 to 0.
REQ-017 FLT_SAMPLE SHALL equal BAUDCE AND (TC in WIN_START..WIN_START+WIN_LEN-1) AND state not IDLE; it is combinational and never coincides with FLT_CLEAR.
REQ-018 The bit-end event SHALL be BAUDCE=1 with TC=OVERSAMPLE-1; FLT_Q SHALL be read only at bit-end.
REQ-019 START bit-end with FLT_Q=1 (false start) SHALL return to IDLE with no DVALID; FLT_Q=0 SHALL go to DATA with bit index 0.
REQ-020 DATA bit-end SHALL store FLT_Q at DOUT bit position index (LSB first); after WLS+5 bits SHALL go to PARITY if PEN=1, else STOP.
REQ-021 Expected parity SHALL be XOR of received data bits when EPS=1, its inverse when EPS=0; PARITY bit-end SHALL record mismatch and go to STOP.
REQ-022 STOP bit-end SHALL: pulse DVALID for exactly one CLK, update DOUT (unused upper bits 0), PE (0 if PEN=0), FE = NOT FLT_Q, then return to IDLE.
REQ-023 DOUT, PE and FE SHALL hold until the next DVALID.
REQ-024 BUSY SHALL be 1 in every state except IDLE.
REQ-025 RXD=0 in the STOP bit-end cycle SHALL NOT start a new frame; start detection resumes from the next BAUDCE in IDLE.
REQ-026 Cycles with BAUDCE=0 SHALL change no state, counter or output except clearing DVALID.

Reset
REQ-027 RST=1 SHALL force IDLE, TC=0, bit index 0, DOUT=0, DVALID=0, PE=0, FE=0, BUSY=0 on the next edge, with priority over all events including mid-frame.
REQ-028 While RST=1, FLT_CLEAR SHALL be 1 and FLT_SAMPLE SHALL be 0.

Verification
REQ-029 With defaults, 8N1, BAUDCE every 4 CLK, send 0xA5 -> exactly one DVALID, DOUT=0xA5, PE=0, FE=0, BUSY=0 after.
REQ-030 WLS=0, PEN=1, EPS=1, send 5'b10110 with parity bit 0 -> DOUT=0x16, PE=1; repeat with parity bit 1 -> PE=0.
REQ-031 RXD low for 3 ticks then high (glitch) -> START ends with FLT_Q=1, no DVALID, IDLE, BUSY=0.
REQ-032 8N1 frame 0x3C with stop bit held 0 -> DVALID, DOUT=0x3C, FE=1.
REQ-033 Assert RST at data bit 3 of a frame -> all outputs 0 next edge; next frame 0x5A received correctly.
REQ-034 Every frame -> FLT_SAMPLE count per bit equals 5 and FLT_CLEAR never coincides with FLT_SAMPLE.
